// File: rtl/snf_rxreq_pkg.sv
// snf_rxreq_pkg: shared CHI request flit type, opcodes and link credit limit
package snf_rxreq_pkg;
  localparam int CHI_CRD_MAX = 15;
  localparam logic [6:0] OP_REQLCRDRETURN = 7'h00;
  localparam logic [6:0] OP_READONCE = 7'h03;
  localparam logic [6:0] OP_READNOSNP = 7'h04;
  localparam logic [6:0] OP_WRITENOSNPPTL = 7'h1C;
  localparam logic [6:0] OP_WRITENOSNPFULL = 7'h1D;
  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [11:0] txnid;
    logic [6:0]  opcode;
    logic [2:0]  size;
    logic [43:0] addr;
  } reqflit_t;
endpackage

// File: rtl/snf_rxreq_if.sv
// snf_rxreq_if: CHI RXREQ link channel between an HN-F transmitter and the SN-F receiver
interface snf_rxreq_if;
  import snf_rxreq_pkg::*;
  logic RXREQFLITPEND;
  logic RXREQFLITV;
  reqflit_t RXREQFLIT;
  logic RXREQLCRDV;
  modport master (output RXREQFLITPEND, output RXREQFLITV, output RXREQFLIT, input RXREQLCRDV);
  modport slave (input RXREQFLITPEND, input RXREQFLITV, input RXREQFLIT, output RXREQLCRDV);
endinterface

// File: rtl/snf_rxreq_fifo.sv
// chi_sync_fifo: single-clock FIFO with occupancy count, used as the request buffer
module chi_sync_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  T mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
  assign dout = mem[rd_q];
  // Storage array; contents need no reset since only counted entries are ever read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q] <= din;
  end
  // Circular pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q == LAST ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/snf_rxreq.sv
// snf_rxreq: CHI SN-F RXREQ receiver issuing L-credits against free buffer space
module snf_rxreq
  import snf_rxreq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  snf_rxreq_if.slave rx,
  output logic req_valid,
  input  logic req_ready,
  output reqflit_t req_flit,
  output logic crd_err,
  output logic [15:0] req_cnt
);
  localparam int W = $clog2(DEPTH + 1);
  localparam int CW = W + 2;
  logic [W-1:0] occ, crd_q, crd_d;
  logic [CW-1:0] committed;
  logic lcrdv_q, lcrdv_d, err_q, err_d, accept, pop, empty, full;
  logic [15:0] cnt_q, cnt_d;
  chi_sync_fifo #(.T(reqflit_t), .DEPTH(DEPTH)) u_buf (
    .clock(clock),
    .reset(reset),
    .push(accept),
    .pop(pop),
    .din(rx.RXREQFLIT),
    .dout(req_flit),
    .empty(empty),
    .full(full),
    .count(occ)
  );
  assign req_valid = !empty;
  assign pop = req_valid & req_ready;
  // Grant a credit only while buffered, granted and in-flight credits leave a free entry
  always_comb begin
    committed = CW'(occ) + CW'(crd_q) + CW'(lcrdv_q);
    accept = rx.RXREQFLITV & (crd_q != '0) & !full;
    lcrdv_d = committed < CW'(DEPTH);
    crd_d = crd_q + W'(lcrdv_q) - W'(accept);
    err_d = err_q | (rx.RXREQFLITV & !accept);
    cnt_d = cnt_q + 16'(accept);
  end
  // Credit, error and accept-count state
  always_ff @(posedge clock) begin
    if (reset) begin
      crd_q <= '0;
      lcrdv_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      crd_q <= crd_d;
      lcrdv_q <= lcrdv_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign rx.RXREQLCRDV = lcrdv_q;
  assign crd_err = err_q;
  assign req_cnt = cnt_q;
endmodule

// File: tb/tb_snf_rxreq.sv
// tb_snf_rxreq: randomized self-checking bench for snf_rxreq against a queue-based link model
module tb_snf_rxreq;
  import snf_rxreq_pkg::*;
  localparam int DEPTH = 4;
  logic clock = 0;
  logic reset = 1;
  logic req_ready = 0;
  logic req_valid, crd_err;
  reqflit_t req_flit;
  logic [15:0] req_cnt;
  int total = 0;
  int bad = 0;
  reqflit_t m_q[$];
  int m_crd = 0;
  bit m_lcrdv = 0;
  bit m_err = 0;
  int m_cnt = 0;

  snf_rxreq_if rx();
  snf_rxreq #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_flit(req_flit),
    .crd_err(crd_err),
    .req_cnt(req_cnt)
  );

  always #5 clock = ~clock;

  function automatic reqflit_t rand_flit();
    logic [95:0] r;
    reqflit_t f;
    r = {$urandom(), $urandom(), $urandom()};
    f = r[$bits(reqflit_t)-1:0];
    f.opcode = ($urandom % 2) ? OP_READNOSNP : OP_WRITENOSNPFULL;
    return f;
  endfunction

  task automatic drive(input bit v, input reqflit_t f, input bit rdy);
    rx.RXREQFLITV = v;
    rx.RXREQFLIT = f;
    rx.RXREQFLITPEND = v;
    req_ready = rdy;
  endtask

  task automatic tick();
    int sz;
    int committed;
    bit acc;
    bit pop;
    sz = m_q.size();
    committed = sz + m_crd + int'(m_lcrdv);
    acc = rx.RXREQFLITV && m_crd > 0 && sz < DEPTH;
    pop = sz > 0 && req_ready;
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_crd = 0;
      m_lcrdv = 0;
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (rx.RXREQFLITV && !acc) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(rx.RXREQFLIT);
      m_crd = m_crd + int'(m_lcrdv) - int'(acc);
      m_lcrdv = committed < DEPTH;
      m_cnt = (m_cnt + int'(acc)) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    drive(0, '0, 0);
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(0, '0, 0);
    repeat (3) tick();
    total++; if (rx.RXREQLCRDV !== 1'b0) begin bad++; $display("FAIL reset_lcrdv got=%b want=0", rx.RXREQLCRDV); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", req_valid); end
    total++; if (crd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", crd_err); end
    total++; if (req_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", req_cnt); end
  endtask

  task automatic test_credit_ramp();
    bit exp;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      exp = c >= 1 && c <= 4;
      total++; if (rx.RXREQLCRDV !== exp) begin bad++; $display("FAIL ramp_lcrdv cycle=%0d got=%b want=%b", c, rx.RXREQLCRDV, exp); end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    reqflit_t f;
    for (int k = 0; k < 4; k++) begin
      f = rand_flit();
      f.opcode = OP_READNOSNP;
      f.txnid = 12'h010 + 12'(k);
      drive(1, f, 0);
      tick();
    end
    drive(0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (req_cnt !== 16'd4) begin bad++; $display("FAIL fill_cnt got=%0d want=4", req_cnt); end
      total++; if (dut.occ !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d want=4", dut.occ); end
      total++; if (rx.RXREQLCRDV !== 1'b0) begin bad++; $display("FAIL fill_nocredit got=%b want=0", rx.RXREQLCRDV); end
      total++; if (req_flit.txnid !== 12'h010 || req_valid !== 1'b1) begin bad++; $display("FAIL fill_hold txnid=%h valid=%b want=010/1", req_flit.txnid, req_valid); end
      tick();
    end
    drive(0, '0, 1);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        total++; if (req_valid !== 1'b1 || req_flit.txnid !== 12'h010 + 12'(k)) begin bad++; $display("FAIL drain_order k=%0d txnid=%h valid=%b want=%h", k, req_flit.txnid, req_valid, 12'h010 + 12'(k)); end
      end
      total++; if (rx.RXREQLCRDV !== m_lcrdv) begin bad++; $display("FAIL drain_lcrdv k=%0d got=%b want=%b", k, rx.RXREQLCRDV, m_lcrdv); end
      tick();
    end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", req_valid); end
  endtask

  task automatic test_no_credit();
    do_reset();
    tick();
    drive(1, rand_flit(), 0);
    total++; if (rx.RXREQLCRDV !== 1'b1) begin bad++; $display("FAIL nocrd_lcrdv got=%b want=1", rx.RXREQLCRDV); end
    tick();
    drive(0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (crd_err !== 1'b1) begin bad++; $display("FAIL nocrd_err got=%b want=1", crd_err); end
      total++; if (req_valid !== 1'b0 || req_cnt !== 16'd0) begin bad++; $display("FAIL nocrd_drop valid=%b cnt=%0d want=0/0", req_valid, req_cnt); end
      tick();
    end
  endtask

  task automatic test_stream();
    int sum;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(m_crd > 0, rand_flit(), 1);
      sum = int'(dut.occ) + int'(dut.crd_q) + int'(dut.lcrdv_q);
      total++; if (sum > DEPTH) begin bad++; $display("FAIL stream_committed k=%0d got=%0d want<=%0d", k, sum, DEPTH); end
      total++; if (crd_err !== 1'b0) begin bad++; $display("FAIL stream_err k=%0d got=%b want=0", k, crd_err); end
      total++; if (rx.RXREQLCRDV !== m_lcrdv) begin bad++; $display("FAIL stream_lcrdv k=%0d got=%b want=%b", k, rx.RXREQLCRDV, m_lcrdv); end
      total++; if (req_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL stream_valid k=%0d got=%b want=%b", k, req_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        total++; if (req_flit !== m_q[0]) begin bad++; $display("FAIL stream_flit k=%0d got=%h want=%h", k, req_flit, m_q[0]); end
      end
      tick();
    end
    drive(0, '0, 1);
    total++; if (req_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL stream_cnt got=%0d want=%0d", req_cnt, m_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, rand_flit(), ($urandom % 3) != 0);
      total++; if (rx.RXREQLCRDV !== m_lcrdv) begin bad++; $display("FAIL rand_lcrdv k=%0d got=%b want=%b", k, rx.RXREQLCRDV, m_lcrdv); end
      total++; if (req_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rand_valid k=%0d got=%b want=%b", k, req_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        total++; if (req_flit !== m_q[0]) begin bad++; $display("FAIL rand_flit k=%0d got=%h want=%h", k, req_flit, m_q[0]); end
      end
      total++; if (crd_err !== m_err) begin bad++; $display("FAIL rand_err k=%0d got=%b want=%b", k, crd_err, m_err); end
      total++; if (req_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rand_cnt k=%0d got=%0d want=%0d", k, req_cnt, m_cnt); end
      tick();
    end
    drive(0, '0, 0);
  endtask

  task automatic test_reset_mid();
    bit exp;
    do_reset();
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_flit(), 0);
      tick();
    end
    drive(0, '0, 0);
    total++; if (req_cnt !== 16'd3 || req_valid !== 1'b1) begin bad++; $display("FAIL mid_setup cnt=%0d valid=%b want=3/1", req_cnt, req_valid); end
    reset = 1;
    tick();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", req_valid); end
    total++; if (rx.RXREQLCRDV !== 1'b0) begin bad++; $display("FAIL mid_lcrdv got=%b want=0", rx.RXREQLCRDV); end
    reset = 0;
    for (int c = 0; c <= 6; c++) begin
      exp = c >= 1 && c <= 4;
      total++; if (rx.RXREQLCRDV !== exp || req_valid !== 1'b0) begin bad++; $display("FAIL mid_ramp cycle=%0d lcrdv=%b valid=%b want=%b/0", c, rx.RXREQLCRDV, req_valid, exp); end
      tick();
    end
  endtask

  task automatic test_accept_pop();
    reqflit_t a;
    reqflit_t b;
    do_reset();
    repeat (5) tick();
    a = rand_flit();
    b = rand_flit();
    drive(1, a, 1);
    tick();
    total++; if (req_valid !== 1'b1 || req_flit !== a) begin bad++; $display("FAIL ap_first valid=%b flit=%h want=1/%h", req_valid, req_flit, a); end
    drive(1, b, 1);
    tick();
    drive(0, '0, 0);
    total++; if (dut.occ !== 3'd1) begin bad++; $display("FAIL ap_occ got=%0d want=1", dut.occ); end
    total++; if (req_valid !== 1'b1 || req_flit !== b) begin bad++; $display("FAIL ap_next valid=%b flit=%h want=1/%h", req_valid, req_flit, b); end
    total++; if (req_cnt !== 16'd2) begin bad++; $display("FAIL ap_cnt got=%0d want=2", req_cnt); end
    tick();
  endtask

  initial begin
    drive(0, '0, 0);
    test_reset();
    test_credit_ramp();
    test_fill_drain();
    test_no_credit();
    test_stream();
    test_random();
    test_reset_mid();
    test_accept_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
